// File: rtl/dose_schedule_controller.sv
// dose_schedule_controller
//   Fetches a patient's dose times from the schedule ROM into a local table,
//   then compares the running 12-hour BCD clock against that table once per
//   second. A match raises an alarm that is cleared by a nurse ack, or by a
//   timeout that counts as a missed dose.
//
// Optional feature: define DOSE_SNOOZE_EN to add the snooze input and the
//   SNOOZE state. Each alarm may be snoozed at most twice, for 5 seconds each.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   state         Control state code (0 reset, 1 set, 2 load, 3 start, 4 idle)
//   patientId     ROM page, captured when a load is triggered
//   currentTime   BCD hh:mm:ss, [23:8] compared against table hh:mm
//   secondTick    one-cycle pulse each time currentTime advances
//   ack           nurse acknowledge pulse
//   snooze        (DOSE_SNOOZE_EN only) snooze request pulse
//   romAddr/romRd ROM read address {patient, slot} and one-cycle read strobe
//   romData       ROM response: [16] entry valid, [15:0] BCD hh:mm
//   busy          high while the table is being fetched
//   alarm         dose alarm active; doseIndex names the slot that raised it
//   missedCount   saturating count of alarms that timed out
module dose_schedule_controller #(
    parameter int NUM_SLOTS     = 4,
    parameter int SLOT_BITS     = 2,
    parameter int ROM_LAT       = 1,
    parameter int ALARM_TIMEOUT = 60,
    parameter int MISS_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             state,
    input  logic [7:0]             patientId,
    input  logic [23:0]            currentTime,
    input  logic                   secondTick,
    input  logic                   ack,
`ifdef DOSE_SNOOZE_EN
    input  logic                   snooze,
`endif
    output logic [8+SLOT_BITS-1:0] romAddr,
    output logic                   romRd,
    input  logic [16:0]            romData,
    output logic                   busy,
    output logic                   alarm,
    output logic [SLOT_BITS-1:0]   doseIndex,
    output logic [MISS_W-1:0]      missedCount
);
    localparam int TO_W  = $clog2(ALARM_TIMEOUT + 1);
    localparam int LAT_W = $clog2(ROM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_ALARM
`ifdef DOSE_SNOOZE_EN
        , S_SNOOZE
`endif
    } fsm_t;

    fsm_t                        fsm_q, fsm_d;
    logic [3:0]                  prev_state_q;
    logic                        running_q, running_d;
    logic [7:0]                  pid_q, pid_d;
    logic [SLOT_BITS-1:0]        slot_q, slot_d;
    logic                        pend_q, pend_d;
    logic [LAT_W-1:0]            lat_q, lat_d;
    logic [NUM_SLOTS-1:0]        valid_q, valid_d;
    logic [NUM_SLOTS-1:0][15:0]  hhmm_q, hhmm_d;
    logic [NUM_SLOTS-1:0]        fired_q, fired_d;
    logic                        loaded_q, loaded_d;
    logic [SLOT_BITS-1:0]        idx_q, idx_d;
    logic [TO_W-1:0]             to_q, to_d;
    logic [MISS_W-1:0]           miss_q, miss_d;
`ifdef DOSE_SNOOZE_EN
    logic [2:0]                  snz_cnt_q, snz_cnt_d;
    logic [1:0]                  snz_used_q, snz_used_d;
`endif

    logic                        load_trig, clr, hit;
    logic [SLOT_BITS-1:0]        hit_idx;
    logic [NUM_SLOTS-1:0]        match;
    logic                        unused_sec;

    // Seconds never take part in matching; a dose is due for a whole minute.
    assign unused_sec = ^currentTime[7:0];

    assign load_trig = (state == 4'd2) && (prev_state_q != 4'd2);
    assign clr       = (state == 4'd0);

    // Lowest matching slot wins; the others fire on later ticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        match   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            match[i] = valid_q[i] && !fired_q[i] && (hhmm_q[i] == currentTime[23:8]);
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = SLOT_BITS'(i);
            end
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        running_d = running_q;
        pid_d     = pid_q;
        slot_d    = slot_q;
        pend_d    = pend_q;
        lat_d     = lat_q;
        valid_d   = valid_q;
        hhmm_d    = hhmm_q;
        fired_d   = fired_q;
        loaded_d  = loaded_q;
        idx_d     = idx_q;
        to_d      = to_q;
        miss_d    = miss_q;
`ifdef DOSE_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
        snz_used_d = snz_used_q;
`endif

        if (state == 4'd3)
            running_d = 1'b1;
        else if (state == 4'd0 || state == 4'd1)
            running_d = 1'b0;

        // Leaving an entry's minute re-arms it for the next 12 h pass.
        if (secondTick && fsm_q != S_IDLE && fsm_q != S_LOAD) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                if (hhmm_q[i] != currentTime[23:8])
                    fired_d[i] = 1'b0;
        end

        case (fsm_q)
            S_LOAD: begin
                if (!pend_q) begin
                    pend_d = 1'b1;               // romRd strobes this cycle
                    lat_d  = '0;
                end else if (lat_q == LAT_W'(ROM_LAT - 1)) begin
                    valid_d[slot_q] = romData[16];
                    hhmm_d[slot_q]  = romData[15:0];
                    pend_d          = 1'b0;
                    if (slot_q == SLOT_BITS'(NUM_SLOTS - 1)) begin
                        slot_d   = '0;
                        loaded_d = 1'b1;
                        fsm_d    = S_ARMED;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ARMED: begin
                if (secondTick && running_q && hit) begin
                    fired_d[hit_idx] = 1'b1;
                    idx_d            = hit_idx;
                    to_d             = '0;
`ifdef DOSE_SNOOZE_EN
                    snz_used_d       = '0;
`endif
                    fsm_d            = S_ALARM;
                end
            end
            S_ALARM: begin
                if (ack) begin
                    fsm_d = S_ARMED;
`ifdef DOSE_SNOOZE_EN
                end else if (snooze && snz_used_q < 2'd2) begin
                    snz_used_d = snz_used_q + 1'b1;
                    snz_cnt_d  = '0;
                    fsm_d      = S_SNOOZE;
`endif
                end else if (secondTick) begin
                    if (to_q == TO_W'(ALARM_TIMEOUT - 1)) begin
                        if (miss_q != '1)
                            miss_d = miss_q + 1'b1;
                        fsm_d = S_ARMED;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
`ifdef DOSE_SNOOZE_EN
            S_SNOOZE: begin
                if (secondTick) begin
                    if (snz_cnt_q == 3'd4) begin
                        to_d  = '0;
                        fsm_d = S_ALARM;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase

        // Load and reset requests override whatever the FSM was doing.
        if (load_trig) begin
            pid_d    = patientId;
            valid_d  = '0;
            fired_d  = '0;
            loaded_d = 1'b0;
            slot_d   = '0;
            pend_d   = 1'b0;
            lat_d    = '0;
            fsm_d    = S_LOAD;
        end else if (clr) begin
            if (fsm_q == S_LOAD) begin
                valid_d  = '0;
                loaded_d = 1'b0;
                slot_d   = '0;
                pend_d   = 1'b0;
                fsm_d    = S_IDLE;
            end else begin
                fired_d = '0;
                miss_d  = '0;
                fsm_d   = loaded_q ? S_ARMED : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            prev_state_q <= '0;
            running_q    <= 1'b0;
            pid_q        <= '0;
            slot_q       <= '0;
            pend_q       <= 1'b0;
            lat_q        <= '0;
            valid_q      <= '0;
            hhmm_q       <= '0;
            fired_q      <= '0;
            loaded_q     <= 1'b0;
            idx_q        <= '0;
            to_q         <= '0;
            miss_q       <= '0;
`ifdef DOSE_SNOOZE_EN
            snz_cnt_q    <= '0;
            snz_used_q   <= '0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= state;
            running_q    <= running_d;
            pid_q        <= pid_d;
            slot_q       <= slot_d;
            pend_q       <= pend_d;
            lat_q        <= lat_d;
            valid_q      <= valid_d;
            hhmm_q       <= hhmm_d;
            fired_q      <= fired_d;
            loaded_q     <= loaded_d;
            idx_q        <= idx_d;
            to_q         <= to_d;
            miss_q       <= miss_d;
`ifdef DOSE_SNOOZE_EN
            snz_cnt_q    <= snz_cnt_d;
            snz_used_q   <= snz_used_d;
`endif
        end
    end

    assign romAddr     = {pid_q, slot_q};
    assign romRd       = (fsm_q == S_LOAD) && !pend_q;
    assign busy        = (fsm_q == S_LOAD);
    assign alarm       = (fsm_q == S_ALARM);
    assign doseIndex   = idx_q;
    assign missedCount = miss_q;

endmodule

// File: tb/tb_dose_schedule_controller.sv
// Scoreboard bench for dose_schedule_controller: expected ROM read addresses
// and expected alarm slots are queued by the stimulus; a monitor pops them
// whenever the DUT strobes romRd or raises alarm.
module tb_dose_schedule_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  state;
    logic [7:0]  patientId;
    logic [23:0] currentTime;
    logic        secondTick;
    logic        ack;
`ifdef DOSE_SNOOZE_EN
    logic        snooze;
`endif
    logic [9:0]  romAddr;
    logic        romRd;
    logic [16:0] romData;
    logic        busy;
    logic        alarm;
    logic [1:0]  doseIndex;
    logic [3:0]  missedCount;

    logic [16:0] rom [0:1023];
    logic [9:0]  rd_q[$];
    logic [1:0]  al_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        alarm_prev = 1'b0;

    dose_schedule_controller dut (
        .clk(clk), .rst_n(rst_n), .state(state), .patientId(patientId),
        .currentTime(currentTime), .secondTick(secondTick), .ack(ack),
`ifdef DOSE_SNOOZE_EN
        .snooze(snooze),
`endif
        .romAddr(romAddr), .romRd(romRd), .romData(romData), .busy(busy),
        .alarm(alarm), .doseIndex(doseIndex), .missedCount(missedCount)
    );

    initial forever #5 clk = ~clk;

    // One-cycle-latency schedule ROM.
    always @(posedge clk) romData <= romRd ? rom[romAddr] : 17'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [9:0] ea;
        logic [1:0] ei;
        forever begin
            @(negedge clk);
            if (romRd) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rom_read unexpected actual=%0h expected=none", romAddr);
                end else begin
                    ea = rd_q.pop_front();
                    chk("rom_addr", 32'(romAddr), 32'(ea));
                end
            end
            if (alarm && !alarm_prev) begin
                if (al_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL alarm unexpected actual_index=%0d expected=none", doseIndex);
                end else begin
                    ei = al_q.pop_front();
                    chk("alarm_index", 32'(doseIndex), 32'(ei));
                end
            end
            alarm_prev = alarm;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic tick(input logic [23:0] t);
        currentTime = t;
        secondTick  = 1'b1;
        step();
        secondTick  = 1'b0;
    endtask

    // Filler ticks at a time with no scheduled dose.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick(24'h090000);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic set_state(input logic [3:0] s);
        state = s;
        step();
        state = 4'd4;
    endtask

    task automatic push_load_reads();
        for (int s = 0; s < 4; s++) rd_q.push_back(10'h014 + 10'(s));
    endtask

    // Trigger a load and count busy cycles, bounded.
    task automatic load_and_count(input string name);
        int n = 0;
        state = 4'd2;
        step();
        state = 4'd4;
        while (busy && n < 50) begin
            n++;
            step();
        end
        chk(name, 32'(n), 32'd8);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 17'h0;
        rom[10'h014] = 17'h1_0830;
        rom[10'h015] = 17'h1_1015;
        rom[10'h016] = 17'h1_1015;
        rom[10'h017] = 17'h1_1100;
        rst_n = 1'b0; state = 4'd4; patientId = 8'h05; currentTime = 24'h0;
        secondTick = 1'b0; ack = 1'b0;
`ifdef DOSE_SNOOZE_EN
        snooze = 1'b0;
`endif
        fork monitor(); join_none
        repeat (3) step();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_romRd", 32'(romRd), 0);
        chk("reset_romAddr", 32'(romAddr), 0);
        chk("reset_index", 32'(doseIndex), 0);
        chk("reset_missed", 32'(missedCount), 0);
        rst_n = 1'b1;
        step();

        // Aborted fetch: two reads issued, then state 0 mid-load.
        rd_q.push_back(10'h014);
        rd_q.push_back(10'h015);
        state = 4'd2; step();
        state = 4'd4; step(); step();
        chk("abort_busy_mid", 32'(busy), 1);
        state = 4'd0; step();
        state = 4'd4;
        chk("abort_busy_after", 32'(busy), 0);
        step(); step();

        push_load_reads();
        load_and_count("load_busy_cycles");

        // Single dose at 08:30.
        set_state(4'd3);
        tick(24'h082959);
        chk("no_alarm_early", 32'(alarm), 0);
        al_q.push_back(2'd0);
        tick(24'h083000);
        chk("alarm_0830", 32'(alarm), 1);
        chk("index_0830", 32'(doseIndex), 0);
        pulse_ack();
        chk("ack_clears", 32'(alarm), 0);
        for (int s = 1; s < 60; s++) tick({16'h0830, bcd(s)});
        chk("no_refire", 32'(alarm), 0);
        tick(24'h083100);

        // Two slots share 10:15: lowest first, the other on the next tick.
        al_q.push_back(2'd1);
        tick(24'h101500);
        chk("index_tie_first", 32'(doseIndex), 1);
        pulse_ack();
        al_q.push_back(2'd2);
        tick(24'h101501);
        chk("index_tie_second", 32'(doseIndex), 2);
        pulse_ack();

        // Timeout: 60 ticks without ack.
        al_q.push_back(2'd3);
        tick(24'h110000);
        wait_ticks(59);
        chk("alarm_before_timeout", 32'(alarm), 1);
        wait_ticks(1);
        chk("alarm_timed_out", 32'(alarm), 0);
        chk("missed_one", 32'(missedCount), 1);

        // Ack on the 60th tick wins.
        al_q.push_back(2'd0);
        tick(24'h083000);
        wait_ticks(59);
        ack = 1'b1;
        tick(24'h090000);
        ack = 1'b0;
        chk("ack_vs_timeout_alarm", 32'(alarm), 0);
        chk("ack_vs_timeout_missed", 32'(missedCount), 1);

        // 15 further misses: counter saturates.
        for (int k = 0; k < 15; k++) begin
            al_q.push_back(2'd0);
            tick(24'h083000);
            wait_ticks(60);
        end
        chk("missed_saturate", 32'(missedCount), 15);

        // Load during an alarm aborts it without a miss.
        al_q.push_back(2'd0);
        tick(24'h083000);
        chk("alarm_before_reload", 32'(alarm), 1);
        push_load_reads();
        state = 4'd2; step(); state = 4'd4;
        chk("reload_alarm_drop", 32'(alarm), 0);
        chk("reload_busy", 32'(busy), 1);
        for (int n = 0; n < 20 && busy; n++) step();
        chk("reload_done", 32'(busy), 0);
        chk("reload_missed_kept", 32'(missedCount), 15);
        set_state(4'd0);
        chk("clr_missed", 32'(missedCount), 0);
        chk("clr_busy", 32'(busy), 0);

        // Table retained after state 0.
        set_state(4'd3);
        tick(24'h090000);
        al_q.push_back(2'd0);
        tick(24'h083000);
        chk("retained_alarm", 32'(alarm), 1);

        // Running cleared mid-alarm: alarm holds; no new matches afterwards.
        set_state(4'd1);
        chk("stop_keeps_alarm", 32'(alarm), 1);
        pulse_ack();
        tick(24'h101500);
        chk("stopped_no_match", 32'(alarm), 0);

`ifdef DOSE_SNOOZE_EN
        set_state(4'd3);
        tick(24'h090000);
        al_q.push_back(2'd0);
        tick(24'h083000);
        for (int r = 0; r < 2; r++) begin
            snooze = 1'b1; step(); snooze = 1'b0;
            chk("snooze_drops", 32'(alarm), 0);
            wait_ticks(4);
            chk("snooze_holding", 32'(alarm), 0);
            al_q.push_back(2'd0);
            wait_ticks(1);
            chk("snooze_reraise", 32'(alarm), 1);
            chk("snooze_index", 32'(doseIndex), 0);
        end
        snooze = 1'b1; step(); snooze = 1'b0;
        chk("third_snooze_ignored", 32'(alarm), 1);
        pulse_ack();
        chk("snooze_ack", 32'(alarm), 0);
`endif

        repeat (4) step();
        chk("rd_queue_empty", 32'(rd_q.size()), 0);
        chk("alarm_queue_empty", 32'(al_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
